// File: rtl/ddr3_pkg.sv
// rtl/ddr3_pkg.sv - command encodings, burst engine states and beat counts shared with the controller
package ddr3_pkg;

  // {CS, RAS, CAS, WE}; any code with CS=1 is a deselect
  localparam logic [3:0] CMD_MRS   = 4'b0000;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_ZQCL  = 4'b0110;
  localparam logic [3:0] CMD_NOP   = 4'b0111;

  localparam logic [7:0] BEATS_BL8 = 8'd8;
  localparam logic [7:0] BEATS_BC4 = 8'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BURST
  } burst_state_t;

endpackage

// File: rtl/ddr3_resp_mem.sv
// rtl/ddr3_resp_mem.sv - byte array with one write port and one registered read port
module ddr3_resp_mem #(
  parameter int COL_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_wr_en,
  input  logic [COL_BITS+2:0] i_wr_addr,
  input  logic [7:0]          i_wr_data,
  input  logic                i_rd_en,
  input  logic [COL_BITS+2:0] i_rd_addr,
  output logic [7:0]          o_rd_data
);

  logic [7:0] r_mem [2**(COL_BITS+3)];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // the read register doubles as the DQ output register, so it idles at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       o_rd_data <= '0;
    else if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
    else              o_rd_data <= '0;
  end

endmodule

// File: rtl/ddr3_cmd_responder.sv
// rtl/ddr3_cmd_responder.sv - DRAM-side command decoder, bank tracker and burst engine for loopback bring-up
module ddr3_cmd_responder
  import ddr3_pkg::*;
#(
  parameter int CL       = 5,
  parameter int CWL      = 5,
  parameter int COL_BITS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CS,
  input  logic        RAS,
  input  logic        CAS,
  input  logic        WE,
  input  logic [14:0] Addr_in,
  input  logic [2:0]  BA_in,
  input  logic [7:0]  dq_in,
  input  logic        dm_in,
  output logic [7:0]  dq_out,
  output logic        dq_oe,
  output logic        dqs_out,
  output logic        dqs_oe,
  output logic [15:0] ref_count,
  output logic        protocol_err,
  output logic [7:0]  bank_open
);

  localparam int         AW    = COL_BITS + 3;
  localparam logic [7:0] L_CL  = 8'(CL);
  localparam logic [7:0] L_CWL = 8'(CWL);

  burst_state_t          r_state;
  logic [7:0]            r_t;
  logic                  r_is_rd, r_bl8, r_ap;
  logic [2:0]            r_ba;
  logic [COL_BITS-1:0]   r_col;
  logic [7:0][14:0]      r_row;

  logic [3:0]    w_cmd;
  logic          w_busy, w_accept, w_done, w_nact, w_nrd;
  logic [7:0]    w_nt, w_nbeats, w_beats, w_lat, w_nlat, w_rd_last;
  logic          w_nxt_dq_oe, w_nxt_dqs_oe, w_wr_en;
  logic [2:0]    w_rd_k, w_wr_k;
  logic [AW-1:0] w_base;
  logic          w_unused_row;

  assign w_cmd    = {CS, RAS, CAS, WE};
  assign w_busy   = (r_state != ST_IDLE);
  assign w_accept = ((w_cmd == CMD_READ) || (w_cmd == CMD_WRITE)) && !w_busy && bank_open[BA_in];
  assign w_beats  = r_bl8 ? BEATS_BL8 : BEATS_BC4;
  assign w_lat    = r_is_rd ? L_CL : L_CWL;
  assign w_done   = w_busy && (r_t == w_lat + w_beats - 8'd1);

  // r_t holds the current cycle number counted from the command; w_nt is the next one
  always_comb begin
    w_nact   = 1'b0;
    w_nt     = r_t + 8'd1;
    w_nrd    = r_is_rd;
    w_nbeats = w_beats;
    if (w_accept) begin
      w_nact   = 1'b1;
      w_nt     = 8'd1;
      w_nrd    = (w_cmd == CMD_READ);
      w_nbeats = Addr_in[12] ? BEATS_BL8 : BEATS_BC4;
    end else if (w_busy && !w_done) begin
      w_nact = 1'b1;
    end
  end

  assign w_nlat       = w_nrd ? L_CL : L_CWL;
  assign w_rd_last    = L_CL + w_nbeats - 8'd1;
  assign w_nxt_dq_oe  = w_nact && w_nrd && (w_nt >= L_CL) && (w_nt <= w_rd_last);
  assign w_nxt_dqs_oe = w_nact && w_nrd && (w_nt >= L_CL - 8'd1) && (w_nt <= w_rd_last);
  assign w_rd_k       = 3'(w_nt - L_CL);
  assign w_wr_k       = 3'(r_t - L_CWL);
  assign w_wr_en      = w_busy && !r_is_rd && (r_t >= L_CWL) && !dm_in;
  assign w_base       = {r_ba, r_col};
  assign w_unused_row = ^r_row;

  ddr3_resp_mem #(.COL_BITS(COL_BITS)) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_base | AW'(w_wr_k)),
    .i_wr_data (dq_in),
    .i_rd_en   (w_nxt_dq_oe),
    .i_rd_addr (w_base | AW'(w_rd_k)),
    .o_rd_data (dq_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_t          <= '0;
      r_is_rd      <= 1'b0;
      r_bl8        <= 1'b0;
      r_ap         <= 1'b0;
      r_ba         <= '0;
      r_col        <= '0;
      r_row        <= '0;
      dq_oe        <= 1'b0;
      dqs_oe       <= 1'b0;
      dqs_out      <= 1'b0;
      ref_count    <= '0;
      protocol_err <= 1'b0;
      bank_open    <= '0;
    end else begin
      // auto-precharge clear comes first so a same-cycle ACT to that bank overrides it
      if (w_done && r_ap) bank_open[r_ba] <= 1'b0;
      case (w_cmd)
        CMD_ACT: begin
          if (bank_open[BA_in]) protocol_err <= 1'b1;
          bank_open[BA_in] <= 1'b1;
          r_row[BA_in]     <= Addr_in;
        end
        CMD_PRE: begin
          if (Addr_in[10]) bank_open <= '0;
          else             bank_open[BA_in] <= 1'b0;
        end
        CMD_REF: begin
          if (|bank_open) protocol_err <= 1'b1;
          if (ref_count != 16'hFFFF) ref_count <= ref_count + 16'd1;
        end
        CMD_READ, CMD_WRITE: begin
          if (w_busy || !bank_open[BA_in]) protocol_err <= 1'b1;
        end
        CMD_NOP, CMD_MRS, CMD_ZQCL: ;
        default: ;
      endcase
      if (w_accept) begin
        r_is_rd <= (w_cmd == CMD_READ);
        r_bl8   <= Addr_in[12];
        r_ap    <= Addr_in[10];
        r_ba    <= BA_in;
        r_col   <= Addr_in[COL_BITS-1:0] & ~(COL_BITS'(3'd7));
      end
      r_state <= !w_nact ? ST_IDLE : ((w_nt >= w_nlat) ? ST_BURST : ST_WAIT);
      r_t     <= w_nact ? w_nt : 8'd0;
      dq_oe   <= w_nxt_dq_oe;
      dqs_oe  <= w_nxt_dqs_oe;
      dqs_out <= w_nxt_dq_oe & ~w_rd_k[0];
    end
  end

endmodule

// File: doc/ddr3_cmd_responder.md
Name: ddr3_cmd_responder

Overview:
- Synthesizable DRAM-side responder for the DDR3 command/data interface driven by our memory controller state machine.
- Decodes CS/RAS/CAS/WE and tracks open rows per bank.
- Stores write bursts into a small on-chip array and returns read bursts after CL cycles; flags protocol violations and counts refreshes.
- Sits on the FPGA opposite the controller for loopback bring-up and regression without a physical DRAM.

Parameters:
- CL, 5, read latency in clk cycles from READ command to first data beat (min 2).
- CWL, 5, write latency in clk cycles from WRITE command to first captured beat (min 1).
- COL_BITS, 6, low column address bits used for storage (min 3); array depth = 8 banks x 2^COL_BITS bytes.

Ports:
- clk  in  1  controller clock (320 MHz); all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- CS, RAS, CAS, WE  in  1 each  active-low command pins.
- Addr_in  in  15  row/column address; bit 10 = auto-precharge / all-banks, bit 12 = BL8(1)/BC4(0).
- BA_in  in  3  bank address.
- dq_in  in  8  write data from the DQ pad.
- dm_in  in  1  write mask (1 = masked, beat not stored).
- dq_out  out  8  read data to the DQ pad.
- dq_oe  out  1  DQ output enable.
- dqs_out  out  1  read strobe (DQS_n is its complement at the top level).
- dqs_oe  out  1  DQS output enable.
- ref_count  out  16  REF commands accepted, saturating at 16'hFFFF.
- protocol_err  out  1  sticky violation flag.
- bank_open  out  8  per-bank row-open status.

Behaviour:
- Reset (async, rst_n=0):
  - dq_out=0, dq_oe=0, dqs_out=0, dqs_oe=0.
  - ref_count=0, protocol_err=0, bank_open=0.
  - Engine IDLE.
  - Array contents are not reset.
- Decode each cycle, with {CS,RAS,CAS,WE}:
  - 1xxx = DES, 0111 = NOP.
  - 0011 = ACT, 0101 = READ, 0100 = WRITE, 0010 = PRE, 0001 = REF, 0000 = MRS, 0110 = ZQCL.
  - MRS, ZQCL, NOP and DES have no effect.
- ACT:
  - Sets bank_open[BA] and stores the row.
  - ACT to an already-open bank sets protocol_err; the row is updated.
- PRE:
  - Addr_in[10]=1 clears all bank_open bits; otherwise clears bank_open[BA] only.
  - PRE to a closed bank is legal.
- REF:
  - Increments ref_count, saturating at 16'hFFFF.
  - REF with any bank_open bit set sets protocol_err; the count still increments.
- READ/WRITE to a closed bank: sets protocol_err; the command is dropped.
- READ/WRITE while the engine is not IDLE: sets protocol_err; the command is dropped. The current burst continues.
- Accepted READ/WRITE latches:
  - BA.
  - col = Addr_in[COL_BITS-1:0], with col[2:0] forced to 0.
  - Burst length 8 if Addr_in[12]=1, else 4.
  - Auto-precharge flag = Addr_in[10].
- Array index = {BA, col[COL_BITS-1:3], beat[2:0]}. Row bits are ignored, so all rows of a bank alias.
- Burst engine states: IDLE -> WAIT -> BURST -> IDLE.
  - WAIT counts the latency: CL-1 cycles for READ, CWL-1 cycles for WRITE.
  - READ WAIT, final cycle (preamble): dqs_oe=1 and dqs_out=0.
  - READ BURST, beat k (cycle CL+k after the command): dq_out = array[k], dq_oe=1, dqs_oe=1, dqs_out = ~k[0].
  - WRITE BURST, beat k (cycle CWL+k after the command): if dm_in=0, store dq_in to array[k]. dq_oe stays 0.
  - After the last beat the engine returns to IDLE, dq_oe=0 and dqs_oe=0 on the next cycle.
  - If auto-precharge is set, bank_open[BA] clears in that same cycle.
- Array reads are synchronous, so the read address is issued one cycle ahead of each beat. dq_out must be registered.
- A same-cycle auto-precharge clear and an ACT to the same bank: the ACT wins and bank_open stays 1.
- Reset asserted mid-burst aborts immediately: outputs go to their reset values and nothing further is stored.

Decomposition:
- Shared package ddr3_pkg holds:
  - the command encoding localparams (CMD_NOP, CMD_ACT, CMD_READ, CMD_WRITE, CMD_PRE, CMD_REF, CMD_MRS, CMD_ZQCL);
  - the burst engine state encoding;
  - BL8/BC4 beat-count constants.
- The controller reuses the same command encodings.
- One sub-module: ddr3_resp_mem, a simple dual-port byte array (one write port, one registered read port), 8 x 2^COL_BITS deep.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 mid-read-burst.
  - Required: dq_oe=0, dqs_oe=0 and bank_open=0 within the same cycle; no further beats appear after release.
- Write then read BL8:
  - Stimulus: ACT bank 5 row 5; WRITE col 1 with A12=1 and data 8'hA5 on all 8 beats at CWL; READ col 1.
  - Required: dq_out=8'hA5 for beats at cycles CL..CL+7 after READ; dqs_out=1,0,1,0,1,0,1,0; dqs_oe high from cycle CL-1 (preamble).
- BC4 with mask:
  - Stimulus: WRITE with A12=0, beats 8'h11, 8'h22, 8'h33, 8'h44, dm_in=1 on beat 2; then a BC4 READ.
  - Required: read returns 8'h11, 8'h22, <previous value>, 8'h44; engine IDLE after 4 beats.
- Auto-precharge:
  - Stimulus: READ with A10=1.
  - Required: bank_open[BA] clears the cycle after the last beat. A subsequent READ to the same bank sets protocol_err and drives no data.
- Refresh:
  - Stimulus: 3 REF commands with all banks closed.
  - Required: ref_count=3, protocol_err=0.
  - Stimulus: ACT, then REF.
  - Required: ref_count=4, protocol_err=1, sticky until reset.
- Overlap:
  - Stimulus: a second READ issued 2 cycles after a first BL8 READ.
  - Required: protocol_err=1; only the first burst of 8 beats appears.
